// File: rtl/bnn_dot_engine.sv
// Binary dot-product engine: streams activation and weight bits from the bit-serial
// memory banks, accumulates XNOR-popcount per neuron and hands out signed results.
module bnn_dot_engine #(
   parameter int XA_W = 10,
   parameter int WA_W = 20,
   parameter int NO_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [10:0]     n_in,
   input  logic [NO_W-1:0] n_out,
   input  logic [XA_W-1:0] x_base,
   input  logic [WA_W-1:0] w_base,
   input  logic [1:0]      x_bank,
   input  logic [1:0]      w_bank,
   output logic [XA_W-1:0] address_x,
   output logic [WA_W-1:0] address_w,
   output logic [1:0]      sel_x,
   output logic [1:0]      sel_w,
   output logic            we_x,
   output logic            we_w,
   input  logic            data_out_x,
   input  logic            data_out_w,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [11:0]     result_data,
   output logic [NO_W-1:0] result_idx,
   output logic            busy,
   output logic            done
);

   // state   | meaning
   // S_IDLE  | waiting for start, config inputs ignored otherwise
   // S_READ  | one activation/weight bit address pair issued per cycle
   // S_DRAIN | absorbs the memory read latency for the last bit
   // S_OUT   | result held on the output until accepted
   // S_DONE  | one-cycle end-of-layer pulse
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [10:0]     n_in_q, n_in_d;
   logic [NO_W-1:0] n_out_q, n_out_d;
   logic [XA_W-1:0] x_base_q, x_base_d;
   logic [1:0]      sel_x_q, sel_x_d;
   logic [1:0]      sel_w_q, sel_w_d;
   logic [10:0]     i_q, i_d;
   logic [NO_W-1:0] k_q, k_d;
   logic [10:0]     pop_q, pop_d;
   logic [XA_W-1:0] addr_x_q, addr_x_d;
   logic [WA_W-1:0] addr_w_q, addr_w_d;
   logic            rd_q, rd_d;
   logic            bit_match;

   assign bit_match = ~(data_out_x ^ data_out_w);

   always_comb begin
      state_d  = state_q;
      n_in_d   = n_in_q;
      n_out_d  = n_out_q;
      x_base_d = x_base_q;
      sel_x_d  = sel_x_q;
      sel_w_d  = sel_w_q;
      i_d      = i_q;
      k_d      = k_q;
      pop_d    = pop_q;
      addr_x_d = addr_x_q;
      addr_w_d = addr_w_q;
      rd_d     = (state_q == S_READ);

      // Data returned this cycle belongs to the address issued in the previous READ cycle.
      if (rd_q) begin
         pop_d = pop_q + {10'd0, bit_match};
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_in_d   = n_in;
               n_out_d  = n_out;
               x_base_d = x_base;
               sel_x_d  = x_bank;
               sel_w_d  = w_bank;
               i_d      = 11'd0;
               k_d      = '0;
               pop_d    = 11'd0;
               addr_x_d = x_base;
               addr_w_d = w_base;
               if ((n_in == 11'd0) || (n_out == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            i_d      = i_q + 11'd1;
            addr_x_d = addr_x_q + XA_W'(1);
            addr_w_d = addr_w_q + WA_W'(1);
            if (i_q == (n_in_q - 11'd1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_OUT;
         end
         S_OUT: begin
            if (result_ready) begin
               if (({1'b0, k_q} + (NO_W + 1)'(1)) < {1'b0, n_out_q}) begin
                  k_d      = k_q + NO_W'(1);
                  i_d      = 11'd0;
                  pop_d    = 11'd0;
                  addr_x_d = x_base_q;
                  state_d  = S_READ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         n_in_q   <= 11'd0;
         n_out_q  <= '0;
         x_base_q <= '0;
         sel_x_q  <= 2'd0;
         sel_w_q  <= 2'd0;
         i_q      <= 11'd0;
         k_q      <= '0;
         pop_q    <= 11'd0;
         addr_x_q <= '0;
         addr_w_q <= '0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_in_q   <= n_in_d;
         n_out_q  <= n_out_d;
         x_base_q <= x_base_d;
         sel_x_q  <= sel_x_d;
         sel_w_q  <= sel_w_d;
         i_q      <= i_d;
         k_q      <= k_d;
         pop_q    <= pop_d;
         addr_x_q <= addr_x_d;
         addr_w_q <= addr_w_d;
         rd_q     <= rd_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign result_valid = (state_q == S_OUT);
   assign result_data  = (state_q == S_OUT) ? ({pop_q, 1'b0} - {1'b0, n_in_q}) : 12'd0;
   assign result_idx   = k_q;
   assign address_x    = addr_x_q;
   assign address_w    = addr_w_q;
   assign sel_x        = busy ? sel_x_q : 2'd0;
   assign sel_w        = busy ? sel_w_q : 2'd0;
   assign we_x         = 1'b0;
   assign we_w         = 1'b0;

endmodule
